// File: rtl/vpu_dispatch.sv
// vpu_dispatch: fetches 80-bit instruction words from a local instruction
// memory, decodes them onto the vector unit's field bus, issues a one-cycle
// start pulse and waits for the done pulse before moving to the next word.
// Execution stops on a HALT word, a reserved type or a completion timeout.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   run_i, abort_i       host start pulse (ignored while busy), synchronous abort
//   base_pc_i            first instruction address, sampled on run
//   imem_addr_o/en_o     registered instruction memory read port
//   imem_dout_i          read data, valid the cycle after imem_en_o is sampled
//   addr_*_o, opcode_o,
//   vpu_type_o, vreg_*_o,
//   vpu_opcode_o,
//   scalar_b_o           decoded instruction fields, held from issue to next decode
//   vpu_start_o          one-cycle issue pulse
//   vpu_done_i           completion pulse from the vector unit
//   busy_o               high while a program is executing
//   halted_o, error_o    sticky status; err_code_o 0 none, 1 reserved, 2 timeout
//   pc_out_o             current program counter
//   retired_o            completed instruction count, saturating
module vpu_dispatch #(
    parameter int unsigned PC_W           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic            abort_i,
    input  logic [PC_W-1:0] base_pc_i,
    output logic [PC_W-1:0] imem_addr_o,
    output logic            imem_en_o,
    input  logic [79:0]     imem_dout_i,
    output logic [12:0]     addr_a_o,
    output logic [12:0]     addr_b_o,
    output logic [12:0]     addr_out_o,
    output logic [12:0]     addr_const_o,
    output logic [9:0]      opcode_o,
    output logic [2:0]      vpu_type_o,
    output logic [2:0]      vreg_dst_o,
    output logic [2:0]      vreg_a_o,
    output logic [2:0]      vreg_b_o,
    output logic [2:0]      vpu_opcode_o,
    output logic            scalar_b_o,
    output logic            vpu_start_o,
    input  logic            vpu_done_i,
    output logic            busy_o,
    output logic            halted_o,
    output logic            error_o,
    output logic [1:0]      err_code_o,
    output logic [PC_W-1:0] pc_out_o,
    output logic [15:0]     retired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFetchWait,
        StDecode,
        StIssue,
        StWaitDone,
        StHalted,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
    logic              imem_en_q, imem_en_d;
    // Instruction word bits [79:2]; bits [1:0] carry no information.
    logic [77:0]       field_q, field_d;
    logic              vpu_start_q, vpu_start_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       retired_q, retired_d;
    logic [CntW-1:0]   tcnt_q, tcnt_d;

    logic [2:0]        dec_type;
    logic              unused_bits;

    assign dec_type    = imem_dout_i[79:77];
    assign unused_bits = ^imem_dout_i[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        imem_en_d   = imem_en_q;
        field_d     = field_q;
        vpu_start_d = vpu_start_q;
        halted_d    = halted_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        retired_d   = retired_q;
        tcnt_d      = tcnt_q;

        if (abort_i) begin
            // Abort only stops the sequencer; status and fields are kept.
            state_d     = StIdle;
            imem_en_d   = 1'b0;
            vpu_start_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHalted, StError: begin
                    if (run_i) begin
                        pc_d       = base_pc_i;
                        halted_d   = 1'b0;
                        error_d    = 1'b0;
                        err_code_d = 2'd0;
                        retired_d  = 16'd0;
                        state_d    = StFetch;
                    end
                end
                StFetch: begin
                    imem_en_d   = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = StFetchWait;
                end
                StFetchWait: begin
                    imem_en_d = 1'b0;
                    state_d   = StDecode;
                end
                StDecode: begin
                    if (dec_type == 3'd7) begin
                        halted_d = 1'b1;
                        state_d  = StHalted;
                    end else if (dec_type[2]) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = StError;
                    end else begin
                        field_d     = imem_dout_i[79:2];
                        // Raised on entry to issue so the pulse covers exactly that cycle.
                        vpu_start_d = 1'b1;
                        state_d     = StIssue;
                    end
                end
                StIssue: begin
                    vpu_start_d = 1'b0;
                    tcnt_d      = '0;
                    state_d     = StWaitDone;
                end
                StWaitDone: begin
                    // Done beats the timeout when both land in the same cycle.
                    if (vpu_done_i) begin
                        if (retired_q != 16'hFFFF) begin
                            retired_d = retired_q + 16'd1;
                        end
                        pc_d    = pc_q + PC_W'(1);
                        state_d = StFetch;
                    end else if (tcnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = StError;
                    end else begin
                        tcnt_d = tcnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            imem_addr_q <= '0;
            imem_en_q   <= 1'b0;
            field_q     <= '0;
            vpu_start_q <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            retired_q   <= 16'd0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            imem_en_q   <= imem_en_d;
            field_q     <= field_d;
            vpu_start_q <= vpu_start_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            retired_q   <= retired_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign imem_addr_o  = imem_addr_q;
    assign imem_en_o    = imem_en_q;
    assign vpu_type_o   = field_q[77:75];
    assign vreg_dst_o   = field_q[74:72];
    assign vreg_a_o     = field_q[71:69];
    assign vreg_b_o     = field_q[68:66];
    assign vpu_opcode_o = field_q[65:63];
    assign scalar_b_o   = field_q[62];
    assign opcode_o     = field_q[61:52];
    assign addr_a_o     = field_q[51:39];
    assign addr_b_o     = field_q[38:26];
    assign addr_out_o   = field_q[25:13];
    assign addr_const_o = field_q[12:0];
    assign vpu_start_o  = vpu_start_q;
    assign busy_o       = !(state_q inside {StIdle, StHalted, StError});
    assign halted_o     = halted_q;
    assign error_o      = error_q;
    assign err_code_o   = err_code_q;
    assign pc_out_o     = pc_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_vpu_dispatch.sv
module tb_vpu_dispatch;

    localparam int unsigned PC_W = 8;
    localparam int unsigned TO   = 16;

    logic            clk;
    logic            rst_n;
    logic            run;
    logic            abort;
    logic [PC_W-1:0] base_pc;
    logic [PC_W-1:0] imem_addr;
    logic            imem_en;
    logic [79:0]     imem_dout;
    logic [12:0]     addr_a, addr_b, addr_out, addr_const;
    logic [9:0]      opcode;
    logic [2:0]      vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode;
    logic            scalar_b;
    logic            vpu_start;
    logic            vpu_done;
    logic            busy, halted, error;
    logic [1:0]      err_code;
    logic [PC_W-1:0] pc_out;
    logic [15:0]     retired;

    vpu_dispatch #(
        .PC_W          (PC_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (run),
        .abort_i     (abort),
        .base_pc_i   (base_pc),
        .imem_addr_o (imem_addr),
        .imem_en_o   (imem_en),
        .imem_dout_i (imem_dout),
        .addr_a_o    (addr_a),
        .addr_b_o    (addr_b),
        .addr_out_o  (addr_out),
        .addr_const_o(addr_const),
        .opcode_o    (opcode),
        .vpu_type_o  (vpu_type),
        .vreg_dst_o  (vreg_dst),
        .vreg_a_o    (vreg_a),
        .vreg_b_o    (vreg_b),
        .vpu_opcode_o(vpu_opcode),
        .scalar_b_o  (scalar_b),
        .vpu_start_o (vpu_start),
        .vpu_done_i  (vpu_done),
        .busy_o      (busy),
        .halted_o    (halted),
        .error_o     (error),
        .err_code_o  (err_code),
        .pc_out_o    (pc_out),
        .retired_o   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [79:0] mk(input int t, input int d, input int a, input int b,
                                       input int op, input int sb, input int opc,
                                       input int aa, input int ab, input int ao,
                                       input int ac);
        logic [79:0] w;
        w = '0;
        w[79:77] = t[2:0];
        w[76:74] = d[2:0];
        w[73:71] = a[2:0];
        w[70:68] = b[2:0];
        w[67:65] = op[2:0];
        w[64]    = sb[0];
        w[63:54] = opc[9:0];
        w[53:41] = aa[12:0];
        w[40:28] = ab[12:0];
        w[27:15] = ao[12:0];
        w[14:2]  = ac[12:0];
        return w;
    endfunction

    // Instruction memory: one-cycle registered read.
    logic [79:0] mem [256];
    always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

    // Vector unit responder: done 'dly' cycles after each start (0 = never).
    int dly  = 5;
    int dcnt = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt     = 0;
            vpu_done = 1'b0;
        end else if (vpu_start) begin
            dcnt     = dly;
            vpu_done = 1'b0;
        end else if (dcnt > 0) begin
            dcnt--;
            vpu_done = (dcnt == 0);
        end else begin
            vpu_done = 1'b0;
        end
    end

    // Start counter and captured fields at each issue.
    int          n_starts = 0;
    logic [79:0] cap_w;
    always @(negedge clk) begin
        if (vpu_start === 1'b1) begin
            n_starts++;
            cap_w = mk(vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode, scalar_b, opcode,
                       addr_a, addr_b, addr_out, addr_const);
        end
    end

    // Behavioural model: program-level view driven by the instruction stream.
    logic            m_active, m_wait, m_start, m_halted, m_error, m_en;
    logic [1:0]      m_code;
    logic [PC_W-1:0] m_pc, m_addr;
    logic [15:0]     m_retired;
    logic [79:0]     m_word, m_w;
    int              m_phase, m_tcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_wait = 0; m_start = 0; m_halted = 0; m_error = 0; m_en = 0;
            m_code = 0; m_pc = 0; m_addr = 0; m_retired = 0; m_word = 0;
            m_phase = 0; m_tcnt = 0;
        end else if (abort) begin
            m_active = 0; m_wait = 0; m_start = 0; m_en = 0;
        end else if (!m_active) begin
            if (run) begin
                m_pc = base_pc; m_halted = 0; m_error = 0; m_code = 0; m_retired = 0;
                m_active = 1; m_phase = 0;
            end
        end else if (!m_wait) begin
            case (m_phase)
                0: begin m_addr = m_pc; m_en = 1; m_phase = 1; end
                1: begin m_en = 0; m_phase = 2; end
                2: begin
                    m_w = mem[m_pc];
                    if (m_w[79:77] == 3'd7) begin
                        m_halted = 1; m_active = 0;
                    end else if (m_w[79:77] >= 3'd4) begin
                        m_error = 1; m_code = 1; m_active = 0;
                    end else begin
                        m_word = m_w; m_start = 1; m_phase = 3;
                    end
                end
                default: begin m_start = 0; m_wait = 1; m_tcnt = 0; end
            endcase
        end else begin
            if (vpu_done) begin
                if (m_retired != 16'hFFFF) m_retired = m_retired + 1;
                m_pc = m_pc + 1; m_wait = 0; m_phase = 0;
            end else if (m_tcnt == TO - 1) begin
                m_error = 1; m_code = 2; m_active = 0; m_wait = 0;
            end else begin
                m_tcnt++;
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("vpu_start", vpu_start, m_start);
            cmp("busy", busy, m_active);
            cmp("halted", halted, m_halted);
            cmp("error", error, m_error);
            cmp("err_code", err_code, m_code);
            cmp("pc_out", pc_out, m_pc);
            cmp("retired", retired, m_retired);
            cmp("imem_en", imem_en, m_en);
            cmp("imem_addr", imem_addr, m_addr);
            cmp("vpu_type", vpu_type, m_word[79:77]);
            cmp("vreg_dst", vreg_dst, m_word[76:74]);
            cmp("vreg_a", vreg_a, m_word[73:71]);
            cmp("vreg_b", vreg_b, m_word[70:68]);
            cmp("vpu_opcode", vpu_opcode, m_word[67:65]);
            cmp("scalar_b", scalar_b, m_word[64]);
            cmp("opcode", opcode, m_word[63:54]);
            cmp("addr_a", addr_a, m_word[53:41]);
            cmp("addr_b", addr_b, m_word[40:28]);
            cmp("addr_out", addr_out, m_word[27:15]);
            cmp("addr_const", addr_const, m_word[14:2]);
        end
    end

    task automatic run_prog(input logic [PC_W-1:0] b);
        @(negedge clk);
        base_pc = b;
        run     = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_stop(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        cmp("stopped in time", busy, 0);
    endtask

    task automatic wait_start(input int maxc);
        int n = 0;
        while (!vpu_start && n < maxc) begin
            @(negedge clk);
            n++;
        end
        cmp("start seen", vpu_start, 1);
    endtask

    int s0;
    int lat;

    initial begin
        rst_n   = 1'b0;
        run     = 1'b0;
        abort   = 1'b0;
        base_pc = '0;
        imem_dout = '0;
        for (int i = 0; i < 256; i++) mem[i] = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem[8'h10] = mk(3, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        mem[8'h20] = mk(0, 0, 0, 0, 0, 0, 'h155, 'h1ABC, 'h0123, 'h1FFF, 'h0AAA);
        mem[8'h30] = mk(5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        mem[8'h40] = mk(1, 1, 2, 3, 4, 1, 'h2A, 5, 6, 7, 8);
        mem[8'hFF] = mk(2, 5, 6, 7, 3, 1, 'h3FF, 'h10, 'h20, 'h30, 'h40);

        // Reset state
        repeat (3) @(negedge clk);
        cmp("reset busy", busy, 0);
        cmp("reset vpu_start", vpu_start, 0);
        cmp("reset imem_en", imem_en, 0);
        cmp("reset retired", retired, 0);
        cmp("reset pc_out", pc_out, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic issue
        s0 = n_starts;
        run_prog(8'h10);
        wait_stop(200);
        cmp("basic starts", n_starts - s0, 1);
        cmp("basic vreg_dst", cap_w[76:74], 2);
        cmp("basic vreg_a", cap_w[73:71], 0);
        cmp("basic vreg_b", cap_w[70:68], 1);
        cmp("basic halted", halted, 1);
        cmp("basic retired", retired, 1);
        cmp("basic pc_out", pc_out, 'h11);

        // Field decode
        dly = 8;
        run_prog(8'h20);
        wait_stop(200);
        cmp("field opcode", cap_w[63:54], 'h155);
        cmp("field addr_a", cap_w[53:41], 'h1ABC);
        cmp("field addr_b", cap_w[40:28], 'h0123);
        cmp("field addr_out", cap_w[27:15], 'h1FFF);
        cmp("field addr_const", cap_w[14:2], 'h0AAA);
        cmp("field held opcode", opcode, 'h155);

        // Reserved type
        s0 = n_starts;
        run_prog(8'h30);
        wait_stop(200);
        cmp("reserved starts", n_starts - s0, 0);
        cmp("reserved error", error, 1);
        cmp("reserved err_code", err_code, 1);
        cmp("reserved retired", retired, 0);

        // Timeout: no done, error after 16 wait cycles
        dly = 0;
        run_prog(8'h40);
        wait_start(50);
        lat = 0;
        while (busy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        cmp("timeout latency", lat, 17);
        cmp("timeout error", error, 1);
        cmp("timeout err_code", err_code, 2);
        cmp("timeout retired", retired, 0);

        // Done on exactly the 16th wait cycle wins
        dly = 16;
        run_prog(8'h40);
        wait_stop(200);
        cmp("edge error", error, 0);
        cmp("edge err_code", err_code, 0);
        cmp("edge halted", halted, 1);
        cmp("edge retired", retired, 1);

        // PC wrap
        dly = 3;
        run_prog(8'hFF);
        wait_start(50);
        cmp("wrap pc first", pc_out, 'hFF);
        wait_stop(200);
        cmp("wrap pc second", pc_out, 'h00);
        cmp("wrap halted", halted, 1);
        cmp("wrap retired", retired, 1);

        // Run while busy is ignored
        dly = 6;
        s0  = n_starts;
        run_prog(8'h10);
        wait_start(50);
        @(negedge clk);
        base_pc = 8'h30;
        run     = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_stop(200);
        cmp("busyrun starts", n_starts - s0, 1);
        cmp("busyrun error", error, 0);
        cmp("busyrun pc_out", pc_out, 'h11);

        // Abort during wait
        dly = 0;
        run_prog(8'h40);
        wait_start(50);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cmp("abort busy", busy, 0);
        s0 = n_starts;
        repeat (20) @(negedge clk);
        cmp("abort no start", n_starts - s0, 0);
        cmp("abort error", error, 0);
        cmp("abort vreg_dst kept", vreg_dst, 1);

        // Asynchronous reset mid-FETCH
        dly = 5;
        run_prog(8'h10);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst busy", busy, 0);
        cmp("rst pc_out", pc_out, 0);
        cmp("rst vreg_dst", vreg_dst, 0);
        cmp("rst imem_en", imem_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_starts;
        repeat (10) @(negedge clk);
        cmp("rst no start", n_starts - s0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vpu_dispatch.md
Name: vpu_dispatch

Overview:
- Instruction sequencer that drives the vector unit's start/done command interface: fetches 80-bit instruction words from a local instruction memory, decodes them into the vector unit's field bus, pulses start, and waits for done before advancing.
- Sits between the host control registers and the SIMD vector unit.
- Stops on a HALT instruction, a reserved type, or a completion timeout.

Parameters:
- PC_W, 8, instruction memory address width. PC wraps modulo 2^PC_W.
- TIMEOUT_CYCLES, 4096, maximum number of WAIT_DONE cycles before an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start pulse; ignored while busy
- abort  in  1  synchronous abort, returns the block to IDLE
- base_pc  in  PC_W  first instruction address, sampled on run
- imem_addr  out  PC_W  registered instruction memory address
- imem_en  out  1  registered read enable
- imem_dout  in  80  read data, valid the cycle after imem_en is sampled high
- addr_a, addr_b, addr_out, addr_const  out  13 each  decoded fields
- opcode  out  10  scalar opcode
- vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode  out  3 each  decoded fields
- scalar_b  out  1  broadcast flag
- vpu_start  out  1  one-cycle issue pulse
- vpu_done  in  1  completion pulse from the vector unit
- busy  out  1  high in every state except IDLE, HALTED and ERROR
- halted  out  1  sticky; set by HALT
- error  out  1  sticky; set on error
- err_code  out  2  error cause: 0 none, 1 reserved type, 2 timeout
- pc_out  out  PC_W  current PC
- retired  out  16  completed instruction count; saturates at 0xFFFF

Behaviour:
- Reset: every output is 0, and the state is IDLE.
- Instruction word layout:
  - [79:77] vpu_type
  - [76:74] vreg_dst
  - [73:71] vreg_a
  - [70:68] vreg_b
  - [67:65] vpu_opcode
  - [64] scalar_b
  - [63:54] opcode
  - [53:41] addr_a
  - [40:28] addr_b
  - [27:15] addr_out
  - [14:2] addr_const
  - [1:0] ignored
- vpu_type meanings: 0–3 are executable. 7 is HALT. 4–6 are reserved.
- States and transitions:
  - IDLE: on run, pc<=base_pc, clear halted, error, err_code and retired, then go to FETCH.
  - FETCH: imem_en<=1, imem_addr<=pc, then go to FETCH_WAIT.
  - FETCH_WAIT: imem_en<=0, then go to DECODE.
  - DECODE: capture imem_dout.
    - Type 7: halted<=1, go to HALTED.
    - Types 4–6: error<=1, err_code<=1, go to ERROR.
    - Otherwise: register all field outputs and go to ISSUE.
  - ISSUE: vpu_start<=1 for exactly one cycle, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE:
    - On vpu_done: retired++, pc<=pc+1 (wraps), go to FETCH.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: error<=1, err_code<=2, go to ERROR.
  - HALTED and ERROR: hold status. A run restarts exactly as from IDLE.
- Field outputs stay stable from ISSUE until the next DECODE; they never change while the vector unit is running.
- vpu_done outside WAIT_DONE is ignored.
- A vpu_done arriving in the same cycle the counter hits the limit wins: the instruction completes and no error is raised.
- abort has priority over every transition. It forces IDLE, imem_en=0 and vpu_start=0, and leaves halted, error, retired and the field outputs unchanged.
- Timing:
  - Fetch-to-issue latency is 3 cycles (FETCH, FETCH_WAIT, DECODE); vpu_start is high in the 4th cycle.
  - After vpu_done, the next vpu_start follows 4 cycles later.
- run is ignored while busy; no restart and no status change.
- HALT and error instructions do not increment retired.
- Reset asserted mid-operation returns everything to reset values immediately, with no start pulse.

Test Plan:
- Basic issue:
  - Stimulus: imem[0x10]=VCOMPUTE (type 3, dst 2, a 0, b 1, op 0), imem[0x11]=HALT; run with base_pc=0x10; bench returns vpu_done 5 cycles after each start.
  - Required: exactly one vpu_start, with vreg_dst=2, vreg_a=0, vreg_b=1; then halted=1, retired=1, pc_out=0x11, busy=0.
- Field decode:
  - Stimulus: scalar word with opcode=0x155, addr_a=0x1ABC, addr_b=0x0123, addr_out=0x1FFF, addr_const=0x0AAA.
  - Required: all field outputs match and are held constant until done.
- Reserved type:
  - Stimulus: type=5 at base_pc.
  - Required: no vpu_start; error=1, err_code=1, retired=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, vpu_done never asserted.
  - Required: ERROR with err_code=2 after 16 WAIT_DONE cycles.
  - Second run: vpu_done on exactly the 16th cycle gives no error.
- PC wrap:
  - Stimulus: base_pc=0xFF, imem[0xFF]=VLOAD, imem[0x00]=HALT.
  - Required: pc_out goes 0xFF then 0x00, halted=1, retired=1.
- Abort and busy:
  - Stimulus: abort during WAIT_DONE; a run pulse while busy.
  - Required: abort gives IDLE next cycle with no further vpu_start; the mid-run run pulse has no effect.
  - Stimulus: rst_n low mid-FETCH.
  - Required: all outputs 0 asynchronously.
